// File: rtl/fast9_segment_test_if.sv
// Bus interface for fast9_segment_test: pixel capture inputs, job launch
// strobe and the corner result outputs. The master side is the FD
// controller / image memory. The slave side is the segment tester.
// Optional macro FD_CORNER_COUNT_EN adds the cornerCount output.
interface fast9_segment_test_if;
  logic [4:0]  regAddr;
  logic [7:0]  pixelIn;
  logic        readen;
  logic [14:0] refAddr;
  logic        busy;
  logic        cornerValid;
  logic        isCorner;
  logic [14:0] cornerAddr;
  logic        errOverrun;
`ifdef FD_CORNER_COUNT_EN
  logic [15:0] cornerCount;

  modport master (
    output regAddr, pixelIn, readen, refAddr,
    input  busy, cornerValid, isCorner, cornerAddr, errOverrun, cornerCount
  );
  modport slave (
    input  regAddr, pixelIn, readen, refAddr,
    output busy, cornerValid, isCorner, cornerAddr, errOverrun, cornerCount
  );
`else
  modport master (
    output regAddr, pixelIn, readen, refAddr,
    input  busy, cornerValid, isCorner, cornerAddr, errOverrun
  );
  modport slave (
    input  regAddr, pixelIn, readen, refAddr,
    output busy, cornerValid, isCorner, cornerAddr, errOverrun
  );
`endif
endinterface

// File: rtl/fast9_segment_test.sv
// FAST-9 segment test. Captures a centre pixel and 16 circle pixels into
// bright/dark masks. On readen it snapshots the masks and scans all 16
// rotations for a contiguous arc of ARC_LEN bits (legal range 9..12).
// The result arrives 17 cycles after readen.
// Handshake: readen is a one-cycle strobe that is always accepted. If it
// arrives while scanning, the running job is dropped and errOverrun pulses.
// cornerValid is a one-cycle strobe with no back-pressure.
// Optional macro FD_CORNER_COUNT_EN adds a saturating per-frame corner
// counter. The counter clears when a job launches with refAddr 543.
module fast9_segment_test #(
  parameter logic [7:0] THRESH  = 8'd20,
  parameter int         ARC_LEN = 9
) (
  input  logic                  clock,
  input  logic                  nReset,
  fast9_segment_test_if.slave   bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  centre_q, centre_d;
  logic [15:0] bright_q, bright_d;
  logic [15:0] dark_q, dark_d;
  logic [15:0] sh_bright_q, sh_bright_d;
  logic [15:0] sh_dark_q, sh_dark_d;
  logic [3:0]  rot_q, rot_d;
  logic        hit_q, hit_d;
  logic [14:0] job_addr_q, job_addr_d;
  logic [14:0] corner_addr_q, corner_addr_d;
  logic        win_b, win_d;
  logic [9:0]  pix_ext, centre_ext, thr_ext;
  logic [4:0]  slot5;
  logic [3:0]  idx;

  // Capture: classify each arriving circle pixel against the stored centre.
  always_comb begin
    centre_d   = centre_q;
    bright_d   = bright_q;
    dark_d     = dark_q;
    pix_ext    = {2'b00, bus.pixelIn};
    centre_ext = {2'b00, centre_q};
    thr_ext    = {2'b00, THRESH};
    slot5      = bus.regAddr - 5'd1;
    if (bus.regAddr == 5'd0) begin
      centre_d = bus.pixelIn;
    end else if (bus.regAddr <= 5'd16) begin
      bright_d[slot5[3:0]] = pix_ext > (centre_ext + thr_ext);
      dark_d[slot5[3:0]]   = (pix_ext + thr_ext) < centre_ext;
    end
  end

  // Arc window for the current rotation. The 4-bit index wraps modulo 16.
  always_comb begin
    win_b = 1'b1;
    win_d = 1'b1;
    idx   = '0;
    for (int i = 0; i < ARC_LEN; i++) begin
      idx   = rot_q + 4'(i);
      win_b = win_b & sh_bright_q[idx];
      win_d = win_d & sh_dark_q[idx];
    end
  end

  // FSM next state plus the job registers. A readen in any state launches a job.
  always_comb begin
    state_d       = state_q;
    sh_bright_d   = sh_bright_q;
    sh_dark_d     = sh_dark_q;
    rot_d         = rot_q;
    hit_d         = hit_q;
    job_addr_d    = job_addr_q;
    corner_addr_d = corner_addr_q;
    case (state_q)
      S_SCAN: begin
        hit_d = hit_q | win_b | win_d;
        rot_d = rot_q + 4'd1;
        if (rot_q == 4'd15) begin
          state_d       = S_DONE;
          corner_addr_d = job_addr_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.readen) begin
      // The shadow copy takes the bypassed capture so that slot 16 can share the readen cycle.
      state_d       = S_SCAN;
      sh_bright_d   = bright_d;
      sh_dark_d     = dark_d;
      rot_d         = 4'd0;
      hit_d         = 1'b0;
      job_addr_d    = bus.refAddr;
      corner_addr_d = corner_addr_q;
    end
  end

  // Outputs decoded from the state. isCorner is gated so that it reads 0 outside the result cycle.
  always_comb begin
    bus.busy        = (state_q == S_SCAN);
    bus.cornerValid = (state_q == S_DONE);
    bus.isCorner    = (state_q == S_DONE) & hit_q;
    bus.cornerAddr  = corner_addr_q;
    bus.errOverrun  = bus.readen & (state_q == S_SCAN);
    dbg_state       = state_q;
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= S_IDLE;
      centre_q      <= '0;
      bright_q      <= '0;
      dark_q        <= '0;
      sh_bright_q   <= '0;
      sh_dark_q     <= '0;
      rot_q         <= '0;
      hit_q         <= 1'b0;
      job_addr_q    <= '0;
      corner_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      centre_q      <= centre_d;
      bright_q      <= bright_d;
      dark_q        <= dark_d;
      sh_bright_q   <= sh_bright_d;
      sh_dark_q     <= sh_dark_d;
      rot_q         <= rot_d;
      hit_q         <= hit_d;
      job_addr_q    <= job_addr_d;
      corner_addr_q <= corner_addr_d;
    end
  end

`ifdef FD_CORNER_COUNT_EN
  logic [15:0] count_q, count_d;

  // Frame corner count. A frame-start launch clears it, and the clear wins over a same-cycle increment.
  always_comb begin
    count_d = count_q;
    if (state_q == S_DONE && hit_q && count_q != 16'hFFFF) count_d = count_q + 16'd1;
    if (bus.readen && bus.refAddr == 15'd543) count_d = 16'd0;
    bus.cornerCount = count_q;
  end

  // Count register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) count_q <= '0;
    else         count_q <= count_d;
  end
`endif

endmodule

// File: tb/tb_fast9_segment_test.sv
// Bench for fast9_segment_test. A pixel-level model predicts each job's
// result and its timing. A compare process checks the DUT outputs against
// the model on every cycle. Directed jobs with literal expectations pin the
// model itself.
module tb_fast9_segment_test;
  localparam int THR = 20;
  localparam int ARC = 9;

  logic       clock = 1'b0;
  logic       nReset = 1'b0;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  fast9_segment_test_if bus();

  fast9_segment_test dut (
    .clock     (clock),
    .nReset    (nReset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Model state.
  // The expected queue holds entries of the form {emit_cycle[31:0], corner, addr[14:0]}.
  logic [47:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] m_bright = '0;
  logic [15:0] m_dark = '0;
  int          m_centre = 0;
  logic [14:0] m_addr_out = '0;
  logic [15:0] m_count = '0;

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // The corner rule in its plain form: some circular run of at least ARC ones exists.
  function automatic bit has_arc(input logic [15:0] m);
    for (int s = 0; s < 16; s++) begin
      int run = 0;
      while (run < 16 && m[(s + run) % 16]) run++;
      if (run >= ARC) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Compare process.
  always @(negedge clock) begin
    logic [47:0] e;
    int          emit;
    bit          exp_valid, exp_busy, exp_corner;
    logic [14:0] exp_addr;
    if (!nReset) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.cornerValid, 0);
      chk("rst_iscorner", bus.isCorner, 0);
      chk("rst_addr", bus.cornerAddr, 0);
      chk("rst_err", bus.errOverrun, 0);
`ifdef FD_CORNER_COUNT_EN
      chk("rst_count", bus.cornerCount, 0);
`endif
      exp_q.delete();
      m_bright = '0; m_dark = '0; m_centre = 0; m_addr_out = '0; m_count = '0;
    end else begin
      exp_valid = 0; exp_busy = 0; exp_corner = 0; exp_addr = m_addr_out; e = '0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        emit = int'(e[47:16]);
        if (emit == cyc) begin
          exp_valid = 1; exp_corner = e[15]; exp_addr = e[14:0];
        end else if (cyc >= emit - 16 && cyc < emit) begin
          exp_busy = 1;
        end
      end
      chk("busy", bus.busy, exp_busy);
      chk("valid", bus.cornerValid, exp_valid);
      chk("overrun", bus.errOverrun, bus.readen && exp_busy);
      chk("corner_addr", bus.cornerAddr, exp_addr);
      if (exp_valid) chk("is_corner", bus.isCorner, exp_corner);
`ifdef FD_CORNER_COUNT_EN
      chk("count", bus.cornerCount, m_count);
`endif
      if (bus.cornerValid) got_q.push_back({bus.isCorner, bus.cornerAddr});
      if (exp_valid) begin
        void'(exp_q.pop_front());
        m_addr_out = exp_addr;
        if (exp_corner && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
      if (bus.regAddr == 5'd0) begin
        m_centre = int'(bus.pixelIn);
      end else if (bus.regAddr <= 5'd16) begin
        m_bright[bus.regAddr - 5'd1] = int'(bus.pixelIn) > m_centre + THR;
        m_dark[bus.regAddr - 5'd1]   = int'(bus.pixelIn) + THR < m_centre;
      end
      if (bus.readen) begin
        if (exp_busy) void'(exp_q.pop_front());
        exp_q.push_back({32'(cyc + 17), has_arc(m_bright) | has_arc(m_dark), bus.refAddr});
        if (bus.refAddr == 15'd543) m_count = '0;
      end
    end
  end

  // Driver tasks.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      bus.readen = 1'b0; bus.regAddr = 5'd31; bus.pixelIn = 8'd0;
    end
  endtask

  task automatic load_job(input int centre, input logic [7:0] pix [16], input logic [14:0] addr);
    @(posedge clock); #1;
    bus.regAddr = 5'd0; bus.pixelIn = 8'(centre); bus.readen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      bus.regAddr = 5'(k); bus.pixelIn = pix[k-1];
      bus.readen = (k == 16); bus.refAddr = addr;
    end
    idle(1);
  endtask

  task automatic expect_result(input string name, input bit corner, input logic [14:0] addr);
    logic [15:0] g;
    for (int i = 0; i < 60 && got_q.size() == 0; i++) @(posedge clock);
    if (got_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=none expected=%0h", name, {corner, addr});
    end else begin
      g = got_q.pop_front();
      chk(name, g, {corner, addr});
    end
  endtask

  task automatic expect_none(input string name, input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    chk(name, 48'(got_q.size()), 0);
  endtask

  // Directed stimulus.
  initial begin
    logic [7:0] p [16];
    bus.regAddr = 5'd31; bus.pixelIn = 8'd0; bus.readen = 1'b0; bus.refAddr = '0;
    idle(3);
    nReset = 1'b1;
    idle(2);

    for (int i = 0; i < 16; i++) p[i] = (i < 9) ? 8'd130 : 8'd100;
    load_job(100, p, 15'd100);
    expect_result("bright_arc9", 1'b1, 15'd100);

    for (int i = 0; i < 16; i++) p[i] = (i >= 13 || i <= 5) ? 8'd70 : 8'd100;
    load_job(100, p, 15'd101);
    expect_result("dark_wrap_arc", 1'b1, 15'd101);

    for (int i = 0; i < 16; i++) p[i] = (i < 8) ? 8'd200 : 8'd100;
    p[8] = 8'd120;
    load_job(100, p, 15'd102);
    expect_result("thresh_equal", 1'b0, 15'd102);

    for (int i = 0; i < 16; i++) p[i] = 8'd255;
    load_job(250, p, 15'd103);
    expect_result("no_overflow", 1'b0, 15'd103);

    for (int i = 0; i < 16; i++) p[i] = 8'd200;
    load_job(10, p, 15'd104);
    expect_result("all_ones", 1'b1, 15'd104);

    // The two jobs launch 21 cycles apart: the second one loads while the first one scans.
    for (int i = 0; i < 16; i++) p[i] = (i < 9) ? 8'd130 : 8'd100;
    load_job(100, p, 15'd10);
    idle(3);
    for (int i = 0; i < 16; i++) p[i] = (i < 8) ? 8'd200 : 8'd100;
    p[8] = 8'd120;
    load_job(100, p, 15'd11);
    expect_result("b2b_first", 1'b1, 15'd10);
    expect_result("b2b_second", 1'b0, 15'd11);

    // Overrun: readen arrives 5 cycles after launch.
    for (int i = 0; i < 16; i++) p[i] = (i >= 13 || i <= 5) ? 8'd70 : 8'd100;
    load_job(100, p, 15'd200);
    idle(3);
    @(posedge clock); #1;
    bus.readen = 1'b1; bus.refAddr = 15'd201;
    idle(1);
    expect_result("overrun_restart", 1'b1, 15'd201);
    expect_none("overrun_no_extra", 25);

    // Reset pulse in the middle of a scan.
    load_job(100, p, 15'd300);
    idle(5);
    nReset = 1'b0;
    @(posedge clock); #1;
    chk("midscan_rst_busy", bus.busy, 0);
    chk("midscan_rst_addr", bus.cornerAddr, 0);
    nReset = 1'b1;
    expect_none("midscan_rst_no_result", 30);

    // Corner count over a frame boundary.
    for (int i = 0; i < 16; i++) p[i] = 8'd200;
    load_job(10, p, 15'd1);
    expect_result("cnt_job1", 1'b1, 15'd1);
`ifdef FD_CORNER_COUNT_EN
    #1 chk("count_1", bus.cornerCount, 1);
`endif
    load_job(10, p, 15'd2);
    expect_result("cnt_job2", 1'b1, 15'd2);
`ifdef FD_CORNER_COUNT_EN
    #1 chk("count_2", bus.cornerCount, 2);
`endif
    load_job(10, p, 15'd3);
    expect_result("cnt_job3", 1'b1, 15'd3);
`ifdef FD_CORNER_COUNT_EN
    #1 chk("count_3", bus.cornerCount, 3);
`endif
    load_job(10, p, 15'd543);
    expect_result("cnt_frame", 1'b1, 15'd543);
`ifdef FD_CORNER_COUNT_EN
    #1 chk("count_frame", bus.cornerCount, 1);
`endif
    idle(3);

    // Final report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
